// File: rtl/param_stack_unit_if.sv
// Control/data bundle between the datapath and the hardware stack.
// The master drives commands and Z-bus data; the slave returns the top of stack and status.
interface param_stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             push;
  logic             pop;
  logic             flush;
  logic             clr_flags;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, flush, clr_flags, din,
    input  dout, count, full, empty, ovf, unf
  );

  modport slave (
    input  push, pop, flush, clr_flags, din,
    output dout, count, full, empty, ovf, unf
  );
endinterface

// File: rtl/param_stack_unit.sv
// Falling-edge hardware stack with its own pointer and sticky overflow/underflow flags.
// The top of stack is muxed combinationally from the entry array, so dout follows count directly.
module stack_entry #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Storage is don't-care after reset, so entries carry no reset.
  always_ff @(negedge clk)
    if (we) q <= d;
endmodule

module param_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  param_stack_unit_if.slave  bus
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("param_stack_unit: DEPTH must be at least 2");
  end
  if (CNT_W != $clog2(DEPTH + 1)) begin : g_bad_cnt_w
    $error("param_stack_unit: CNT_W must equal clog2(DEPTH+1)");
  end

  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            top_idx, wr_idx;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic                        wr_en;
  logic                        full, empty;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            top_word;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign top_idx = count_q - CNT_W'(1);

  // Priority: flush > push&pop > push > pop. Error flags use set-wins over clr_flags.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q & ~bus.clr_flags;
    unf_d   = unf_q & ~bus.clr_flags;
    wr_en   = 1'b0;
    wr_idx  = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (bus.push && bus.pop) begin
      wr_en = 1'b1;
      if (empty) begin
        wr_idx  = '0;
        count_d = CNT_W'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (bus.push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = count_q;
        count_d = count_q + CNT_W'(1);
      end
    end else if (bus.pop) begin
      if (empty) unf_d = 1'b1;
      else       count_d = top_idx;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    stack_entry #(.WIDTH(WIDTH)) u_entry (
      .clk (clk),
      .we  (wr_en && (wr_idx == CNT_W'(i))),
      .d   (bus.din),
      .q   (mem_q[i])
    );
  end

  // Compare-based read mux keeps non-power-of-2 depths free of out-of-range selects.
  always_comb begin
    top_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (top_idx == CNT_W'(i)) top_word = mem_q[i];
  end

  assign bus.dout  = empty ? '0 : top_word;
  assign bus.count = count_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule
